// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the RV32 multi-cycle control path.
//   - opcode constants for the supported instruction classes
//   - ctrl_state_t: control FSM state encoding
//   - alu_op_t and ALU operation constants ({funct7[5], funct3} encoding)
//   - trap_cause_t: encoding of the sticky trap cause
//   - branch_taken(): branch condition evaluation from funct3 and ALU flags
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } ctrl_state_t;

    // ALU op codes follow the R-type {funct7[5], funct3} layout so OP
    // instructions can pass their fields straight through.
    typedef logic [3:0] alu_op_t;
    localparam alu_op_t ALU_ADD  = 4'b0000;
    localparam alu_op_t ALU_SLL  = 4'b0001;
    localparam alu_op_t ALU_SLT  = 4'b0010;
    localparam alu_op_t ALU_SLTU = 4'b0011;
    localparam alu_op_t ALU_XOR  = 4'b0100;
    localparam alu_op_t ALU_SRL  = 4'b0101;
    localparam alu_op_t ALU_OR   = 4'b0110;
    localparam alu_op_t ALU_AND  = 4'b0111;
    localparam alu_op_t ALU_SUB  = 4'b1000;
    localparam alu_op_t ALU_SRA  = 4'b1101;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_IMEM_TO = 2'b10,
        CAUSE_DMEM_TO = 2'b11
    } trap_cause_t;

    // funct3[2:1] selects the flag (00 eq, 10 signed lt, 11 unsigned lt),
    // funct3[0] inverts it (BNE/BGE/BGEU).
    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic zero,
                                          input logic lt,
                                          input logic ltu);
        logic cond;
        case (f3[2:1])
            2'b00:   cond = zero;
            2'b10:   cond = lt;
            2'b11:   cond = ltu;
            default: cond = 1'b0;
        endcase
        return cond ^ f3[0];
    endfunction

endpackage

// File: rtl/inst_legal_check.sv
// inst_legal_check: purely combinational instruction classifier.
//   opcode/funct3/funct7 in  - decoder fields
//   is_load/is_store/is_op/is_branch out - one-hot opcode class (all 0 for
//                                          unknown opcodes)
//   legal out - instruction belongs to the supported subset
module inst_legal_check
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       is_load,
    output logic       is_store,
    output logic       is_op,
    output logic       is_branch,
    output logic       legal
);

    logic load_ok;
    logic store_ok;
    logic op_ok;
    logic branch_ok;

    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_op     = (opcode == OPC_OP);
    assign is_branch = (opcode == OPC_BRANCH);

    // LB/LH/LW/LBU/LHU
    assign load_ok   = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
    // SB/SH/SW
    assign store_ok  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    // Base R-type, plus SUB and SRA as the only funct7=0100000 encodings
    assign op_ok     = (funct7 == 7'b0000000) ||
                       ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    assign branch_ok = (funct3 != 3'b010) && (funct3 != 3'b011);

    assign legal = (is_load & load_ok) | (is_store & store_ok) |
                   (is_op & op_ok) | (is_branch & branch_ok);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM sequencing fetch/decode/execute/memory/
// writeback for the RV32 multi-cycle core.
//   clk, rst_n                - clock, asynchronous active-low reset
//   opcode, funct3, funct7    - decoder fields (stable from DECODE onward)
//   alu_zero, alu_lt, alu_ltu - ALU comparison flags for branches
//   imem_req/imem_ack         - instruction fetch handshake
//   dmem_req/dmem_we/dmem_ack - data access handshake
//   ir_we, pc_we, pc_sel, rf_we, wb_sel, alu_src_imm, alu_op - datapath ctrl
//   instret                   - retired-instruction counter (counts pc_we)
//   trap, trap_cause          - sticky halt flag and its cause
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic        alu_zero,
    input  logic        alu_lt,
    input  logic        alu_ltu,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        alu_src_imm,
    output logic [3:0]  alu_op,
    output logic [31:0] instret,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    ctrl_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    trap_cause_t      cause_reg, cause_next;
    logic             trap_reg;
    logic [31:0]      instret_reg;

    logic is_load, is_store, is_op, is_branch, legal;

    inst_legal_check u_legal (
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .is_load   (is_load),
        .is_store  (is_store),
        .is_op     (is_op),
        .is_branch (is_branch),
        .legal     (legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            cause_reg   <= CAUSE_NONE;
            trap_reg    <= 1'b0;
            instret_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            cause_reg   <= cause_next;
            if (state_next == ST_TRAP) begin
                trap_reg <= 1'b1;
            end
            if (pc_we) begin
                instret_reg <= instret_reg + 32'd1;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = '0;  // cleared on every transition; wait loops override
        cause_next  = cause_reg;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = 1'b0;
        rf_we       = 1'b0;
        wb_sel      = 1'b0;
        alu_src_imm = 1'b0;
        alu_op      = ALU_ADD;

        case (state_reg)
            ST_IDLE: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                // An ack arriving in the final allowed cycle still wins.
                if (imem_ack) begin
                    ir_we      = 1'b1;
                    state_next = ST_DECODE;
                end else if (cnt_reg == CNT_LIMIT) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_IMEM_TO;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_DECODE: begin
                if (legal) begin
                    state_next = ST_EXEC;
                end else begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_ILLEGAL;
                end
            end
            ST_EXEC: begin
                if (is_op) begin
                    alu_op     = {funct7[5], funct3};
                    state_next = ST_WB;
                end else if (is_load || is_store) begin
                    alu_src_imm = 1'b1;
                    state_next  = ST_MEM;
                end else if (is_branch) begin
                    alu_op     = ALU_SUB;
                    pc_we      = 1'b1;
                    pc_sel     = branch_taken(funct3, alu_zero, alu_lt, alu_ltu);
                    state_next = ST_FETCH;
                end else begin
                    // Only reachable if the IR changed after DECODE.
                    state_next = ST_TRAP;
                    cause_next = CAUSE_ILLEGAL;
                end
            end
            ST_MEM: begin
                dmem_req    = 1'b1;
                dmem_we     = is_store;
                alu_src_imm = 1'b1;
                if (dmem_ack) begin
                    if (is_load) begin
                        state_next = ST_WB;
                    end else begin
                        pc_we      = 1'b1;
                        state_next = ST_FETCH;
                    end
                end else if (cnt_reg == CNT_LIMIT) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_DMEM_TO;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_WB: begin
                rf_we      = 1'b1;
                wb_sel     = is_load;
                pc_we      = 1'b1;
                state_next = ST_FETCH;
            end
            ST_TRAP: begin
                state_next = ST_TRAP;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign instret    = instret_reg;
    assign trap       = trap_reg;
    assign trap_cause = cause_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl.
// Control outputs are packed into one vector and compared against
// hand-written expected vectors; inputs change 2 time units after the
// rising edge and outputs are checked 1 time unit later.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        alu_zero, alu_lt, alu_ltu;
    logic        imem_req, imem_ack;
    logic        dmem_req, dmem_we, dmem_ack;
    logic        ir_we, pc_we, pc_sel, rf_we, wb_sel, alu_src_imm;
    logic [3:0]  alu_op;
    logic [31:0] instret;
    logic        trap;
    logic [1:0]  trap_cause;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] L_LOAD   = 7'b0000011;
    localparam logic [6:0] L_STORE  = 7'b0100011;
    localparam logic [6:0] L_OP     = 7'b0110011;
    localparam logic [6:0] L_BRANCH = 7'b1100011;
    localparam logic [6:0] L_OPIMM  = 7'b0010011;

    multicycle_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .alu_zero    (alu_zero),
        .alu_lt      (alu_lt),
        .alu_ltu     (alu_ltu),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel),
        .rf_we       (rf_we),
        .wb_sel      (wb_sel),
        .alu_src_imm (alu_src_imm),
        .alu_op      (alu_op),
        .instret     (instret),
        .trap        (trap),
        .trap_cause  (trap_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] outs;
    assign outs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we,
                   wb_sel, alu_src_imm, alu_op, trap, trap_cause};

    // Expected output vector, same field order as outs.
    function automatic logic [15:0] ev(input logic ireq, input logic dreq,
                                       input logic dwe, input logic irwe,
                                       input logic pcwe, input logic pcsel,
                                       input logic rfwe, input logic wbsel,
                                       input logic asi, input logic [3:0] aop,
                                       input logic tr, input logic [1:0] tc);
        return {ireq, dreq, dwe, irwe, pcwe, pcsel, rfwe, wbsel, asi, aop, tr, tc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Entered in the first FETCH cycle; leaves the FSM in DECODE.
    task automatic fetch_inst(input int waits, input logic [6:0] opc,
                              input logic [2:0] f3, input logic [6:0] f7);
        for (int i = 0; i < waits; i++) begin
            #1 chk("fetch_wait", {16'h0, outs}, {16'h0, ev(1,0,0,0,0,0,0,0,0,4'h0,0,2'b00)});
            tick();
        end
        imem_ack = 1'b1;
        opcode   = opc;
        funct3   = f3;
        funct7   = f7;
        #1 chk("fetch_ack", {16'h0, outs}, {16'h0, ev(1,0,0,1,0,0,0,0,0,4'h0,0,2'b00)});
        tick();
        imem_ack = 1'b0;
        #1 chk("decode", {16'h0, outs}, 32'h0);
    endtask

    // Asynchronous reset pulse; leaves the FSM in its first FETCH cycle.
    task automatic do_reset;
        rst_n = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        #1 chk("reset_outs", {16'h0, outs}, 32'h0);
        chk("reset_instret", instret, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        opcode = '0; funct3 = '0; funct7 = '0;
        alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0;

        // Reset state
        #3 chk("por_outs", {16'h0, outs}, 32'h0);
        chk("por_instret", instret, 32'h0);
        tick();
        rst_n = 1'b1;
        #1 chk("idle_outs", {16'h0, outs}, 32'h0);
        tick();

        // ADD, ack on the 2nd FETCH cycle
        fetch_inst(1, L_OP, 3'b000, 7'b0000000);
        tick();
        #1 chk("add_exec", {16'h0, outs}, {16'h0, ev(0,0,0,0,0,0,0,0,0,4'b0000,0,2'b00)});
        tick();
        #1 chk("add_wb", {16'h0, outs}, {16'h0, ev(0,0,0,0,1,0,1,0,0,4'b0000,0,2'b00)});
        chk("add_wb_instret", instret, 32'd0);
        tick();
        #1 chk("add_instret", instret, 32'd1);
        $display("txn ADD instret=%0d", instret);

        // LW with three dmem wait cycles
        fetch_inst(0, L_LOAD, 3'b010, 7'b0000000);
        tick();
        #1 chk("lw_exec", {16'h0, outs}, {16'h0, ev(0,0,0,0,0,0,0,0,1,4'b0000,0,2'b00)});
        tick();
        for (int i = 0; i < 3; i++) begin
            #1 chk("lw_mem_wait", {16'h0, outs}, {16'h0, ev(0,1,0,0,0,0,0,0,1,4'b0000,0,2'b00)});
            tick();
        end
        dmem_ack = 1'b1;
        #1 chk("lw_mem_ack", {16'h0, outs}, {16'h0, ev(0,1,0,0,0,0,0,0,1,4'b0000,0,2'b00)});
        tick();
        dmem_ack = 1'b0;
        #1 chk("lw_wb", {16'h0, outs}, {16'h0, ev(0,0,0,0,1,0,1,1,0,4'b0000,0,2'b00)});
        tick();
        #1 chk("lw_instret", instret, 32'd2);
        $display("txn LW instret=%0d", instret);

        // SW, immediate ack: pc_we in the MEM ack cycle, no rf_we
        fetch_inst(0, L_STORE, 3'b010, 7'b0000000);
        tick();
        tick();
        dmem_ack = 1'b1;
        #1 chk("sw_mem_ack", {16'h0, outs}, {16'h0, ev(0,1,1,0,1,0,0,0,1,4'b0000,0,2'b00)});
        tick();
        dmem_ack = 1'b0;
        #1 chk("sw_next_fetch", {16'h0, outs}, {16'h0, ev(1,0,0,0,0,0,0,0,0,4'h0,0,2'b00)});
        chk("sw_instret", instret, 32'd3);
        $display("txn SW instret=%0d", instret);

        // BNE not-zero -> taken
        fetch_inst(0, L_BRANCH, 3'b001, 7'b0000000);
        tick();
        alu_zero = 1'b0;
        #1 chk("bne_taken", {16'h0, outs}, {16'h0, ev(0,0,0,0,1,1,0,0,0,4'b1000,0,2'b00)});
        tick();
        #1 chk("bne_taken_instret", instret, 32'd4);
        $display("txn BNE taken instret=%0d", instret);

        // BNE zero -> not taken
        fetch_inst(0, L_BRANCH, 3'b001, 7'b0000000);
        tick();
        alu_zero = 1'b1;
        #1 chk("bne_not_taken", {16'h0, outs}, {16'h0, ev(0,0,0,0,1,0,0,0,0,4'b1000,0,2'b00)});
        tick();
        alu_zero = 1'b0;
        #1 chk("bne_nt_instret", instret, 32'd5);
        $display("txn BNE not-taken instret=%0d", instret);

        // BGEU with ltu=0 -> taken
        fetch_inst(0, L_BRANCH, 3'b111, 7'b0000000);
        tick();
        alu_ltu = 1'b0;
        #1 chk("bgeu_taken", {16'h0, outs}, {16'h0, ev(0,0,0,0,1,1,0,0,0,4'b1000,0,2'b00)});
        tick();
        $display("txn BGEU instret=%0d", instret);

        // BLT with lt=0 -> not taken, zero=1 must not matter
        fetch_inst(0, L_BRANCH, 3'b100, 7'b0000000);
        tick();
        alu_lt = 1'b0; alu_zero = 1'b1; alu_ltu = 1'b1;
        #1 chk("blt_not_taken", {16'h0, outs}, {16'h0, ev(0,0,0,0,1,0,0,0,0,4'b1000,0,2'b00)});
        tick();
        alu_zero = 1'b0; alu_ltu = 1'b0;
        #1 chk("blt_instret", instret, 32'd7);
        $display("txn BLT instret=%0d", instret);

        // SRA, fetch ack on the 16th cycle (last before timeout): no trap
        fetch_inst(15, L_OP, 3'b101, 7'b0100000);
        chk("ack16_no_trap", {30'h0, trap, trap_cause[0]}, 32'h0);
        tick();
        #1 chk("sra_exec", {16'h0, outs}, {16'h0, ev(0,0,0,0,0,0,0,0,0,4'b1101,0,2'b00)});
        tick();
        tick();
        #1 chk("sra_instret", instret, 32'd8);
        $display("txn SRA late-ack instret=%0d", instret);

        // Illegal OP funct7=0100000 funct3=001
        fetch_inst(0, L_OP, 3'b001, 7'b0100000);
        tick();
        #1 chk("illegal_op_trap", {16'h0, outs}, {16'h0, ev(0,0,0,0,0,0,0,0,0,4'h0,1,2'b01)});
        $display("txn illegal OP cause=%0b", trap_cause);

        // Illegal opcode 0010011; TRAP stays silent even with acks present
        do_reset();
        fetch_inst(0, L_OPIMM, 3'b000, 7'b0000000);
        tick();
        #1 chk("illegal_opc_trap", {16'h0, outs}, {16'h0, ev(0,0,0,0,0,0,0,0,0,4'h0,1,2'b01)});
        imem_ack = 1'b1; dmem_ack = 1'b1;
        tick();
        tick();
        #1 chk("trap_sticky", {16'h0, outs}, {16'h0, ev(0,0,0,0,0,0,0,0,0,4'h0,1,2'b01)});
        chk("trap_instret", instret, 32'd0);
        $display("txn illegal opcode cause=%0b", trap_cause);

        // imem timeout: 16 FETCH cycles without ack
        do_reset();
        for (int i = 0; i < 16; i++) begin
            #1 chk("imem_to_wait", {16'h0, outs}, {16'h0, ev(1,0,0,0,0,0,0,0,0,4'h0,0,2'b00)});
            tick();
        end
        #1 chk("imem_to_trap", {16'h0, outs}, {16'h0, ev(0,0,0,0,0,0,0,0,0,4'h0,1,2'b10)});
        $display("txn imem timeout cause=%0b", trap_cause);

        // dmem timeout: LB never acked
        do_reset();
        fetch_inst(0, L_LOAD, 3'b000, 7'b0000000);
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            #1 chk("dmem_to_wait", {16'h0, outs}, {16'h0, ev(0,1,0,0,0,0,0,0,1,4'h0,0,2'b00)});
            tick();
        end
        #1 chk("dmem_to_trap", {16'h0, outs}, {16'h0, ev(0,0,0,0,0,0,0,0,0,4'h0,1,2'b11)});
        $display("txn dmem timeout cause=%0b", trap_cause);

        // Reset asserted mid-MEM after one retired instruction
        do_reset();
        fetch_inst(0, L_OP, 3'b111, 7'b0000000);
        tick();
        tick();
        tick();
        #1 chk("pre_rst_instret", instret, 32'd1);
        fetch_inst(0, L_LOAD, 3'b100, 7'b0000000);
        tick();
        tick();
        #1 chk("mid_mem_req", {31'h0, dmem_req}, 32'h1);
        rst_n = 1'b0;
        #1 chk("mid_mem_rst_outs", {16'h0, outs}, 32'h0);
        chk("mid_mem_rst_instret", instret, 32'd0);
        tick();
        rst_n = 1'b1;
        #1 chk("post_rst_idle", {16'h0, outs}, 32'h0);
        tick();
        #1 chk("post_rst_fetch", {16'h0, outs}, {16'h0, ev(1,0,0,0,0,0,0,0,0,4'h0,0,2'b00)});
        $display("txn mid-MEM reset instret=%0d", instret);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32 core. It sequences fetch, decode, execute, memory and writeback around the instruction decoder, register file, ALU and memory ports. It consumes decoder fields (opcode, funct3, funct7) and ALU flags. It produces register and PC write enables, datapath selects, ALU op codes, memory handshakes, and a trap/halt indication. Supported opcode classes: LOAD 0000011, STORE 0100011, OP 0110011 and BRANCH 1100011.

Parameters:
TIMEOUT_CYCLES, 16, max cycles a memory request may wait for ack before a bus-error trap (>=1)
CNT_W, $clog2(TIMEOUT_CYCLES+1), derived width of the wait counter (localparam)

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
opcode  in  7  decoder inst[6:0]
funct3  in  3  decoder funct3
funct7  in  7  decoder funct7
alu_zero  in  1  ALU result==0
alu_lt  in  1  signed rs1<rs2
alu_ltu  in  1  unsigned rs1<rs2
imem_req  out  1  instruction fetch request, held until ack
imem_ack  in  1  fetch data valid this cycle
dmem_req  out  1  data request, held until ack
dmem_we  out  1  1=store, 0=load; valid while dmem_req
dmem_ack  in  1  data access complete this cycle
ir_we  out  1  latch instruction register
pc_we  out  1  update PC
pc_sel  out  1  0=PC+4, 1=branch target
rf_we  out  1  register file write
wb_sel  out  1  0=ALU result, 1=load data
alu_src_imm  out  1  ALU operand B: 0=rs2, 1=imm
alu_op  out  4  ALU operation code
instret  out  32  retired-instruction counter
trap  out  1  sticky halt flag
trap_cause  out  2  00 none, 01 illegal instruction, 10 imem timeout, 11 dmem timeout

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. State, wait counter, instret, trap and trap_cause are registered.
- Other outputs are combinational from state and inputs, and are 0 outside the states listed below.
- Reset (asynchronous, any state, mid-request included): state=IDLE, instret=0, trap=0, trap_cause=00, counter=0, all outputs 0.
- IDLE: all outputs 0; goes to FETCH next cycle.
- FETCH: imem_req=1.
  - imem_ack: ir_we=1, then DECODE.
  - Otherwise counter increments; when counter==TIMEOUT_CYCLES-1 with no ack, go to TRAP, cause 10.
  - Ack in the same cycle as timeout: ack wins.
- DECODE: 1 cycle, legality check, then EXEC. Illegal goes to TRAP, cause 01. Legal set:
  - LOAD funct3 in {000,001,010,100,101}.
  - STORE funct3 in {000,001,010}.
  - OP with funct7=0000000 (any funct3), or funct7=0100000 with funct3 in {000,101}.
  - BRANCH funct3 not in {010,011}.
  - Any other opcode is illegal.
- EXEC:
  - OP: alu_src_imm=0, alu_op={funct7[5],funct3}, then WB.
  - LOAD/STORE: alu_src_imm=1, alu_op=0000 (ADD), then MEM.
  - BRANCH: alu_src_imm=0, alu_op=1000 (SUB), pc_we=1, then FETCH.
    - pc_sel=taken, where taken is: BEQ zero, BNE !zero, BLT lt, BGE !lt, BLTU ltu, BGEU !ltu.
- MEM: dmem_req=1, dmem_we=(STORE); alu_op/alu_src_imm held as in EXEC.
  - On ack, LOAD goes to WB.
  - On ack, STORE: pc_we=1, pc_sel=0, then FETCH.
  - Timeout rule as in FETCH; goes to TRAP, cause 11.
- WB: rf_we=1, wb_sel=(LOAD), pc_we=1, pc_sel=0, then FETCH.
- The wait counter clears on every state transition.
- instret increments by 1 in every cycle with pc_we=1; wraps 0xFFFFFFFF->0.
- TRAP: trap=1, cause holds, all other outputs 0. Exit only via rst_n.
- The opcode/funct fields must stay stable from the DECODE cycle through the end of the instruction (the IR guarantees this).
- Latency without wait states: R-type 4, branch 3, store 4, load 5 cycles from FETCH entry to next FETCH entry.

Decomposition:
- riscv_pkg:
  - opcode localparams OPC_LOAD/OPC_STORE/OPC_OP/OPC_BRANCH
  - ctrl_state_t enum
  - alu_op_t constants (ADD=0000, SUB=1000, ...)
  - trap_cause_t
- One combinational sub-module, inst_legal_check: takes opcode/funct3/funct7 and produces legal, plus one-hot class is_load/is_store/is_op/is_branch. It is reused by the decoder assertions bench.

Test Plan:
- Reset, release rst_n, imem_ack on the 2nd FETCH cycle, inst ADD (opcode 0110011, funct7 0, funct3 000):
  - ir_we one cycle; EXEC alu_op=0000; WB rf_we=1, wb_sel=0, pc_we=1; instret=1.
- LOAD LW (funct3 010), dmem_ack after 3 wait cycles:
  - dmem_req high 4 cycles, dmem_we=0, then WB rf_we=1, wb_sel=1; SW variant gives dmem_we=1, no rf_we, pc_we in MEM ack cycle.
- BNE with alu_zero=0, then with alu_zero=1:
  - pc_we=1 with pc_sel=1, then pc_sel=0; rf_we never asserted; BGEU with alu_ltu=0 gives pc_sel=1.
- Illegal inputs:
  - opcode 0010011: TRAP cause 01, trap=1, all outputs 0 thereafter.
  - OP funct7=0100000 funct3=001: cause 01.
- Timeouts and reset:
  - imem_ack never with TIMEOUT_CYCLES=16: trap after 16 FETCH cycles, cause 10.
  - Ack on the 16th cycle: no trap.
  - rst_n pulsed low mid-MEM: dmem_req drops immediately, state IDLE, instret=0.
